// File: rtl/aes128_pkg.sv
// Shared definitions for the AES-128 decrypt stream controller.
//   state_e         : controller FSM states (2-bit)
//   WORDS_PER_BLOCK : 32-bit words per 128-bit block
//   IDX_W           : width of the word-index counters
package aes128_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        WAIT   = 2'd1,
        UNLOAD = 2'd2
    } state_e;

    localparam int unsigned WORDS_PER_BLOCK = 4;
    localparam int unsigned IDX_W           = 2;

endpackage

// File: rtl/aes128_dec_stream_ctrl.sv
// Word-serial front/back end for an AES-128 ECB decryption core.
// Collects key and ciphertext words from a valid/ready stream, holds them
// stable on the core inputs for CORE_LATENCY cycles, captures the core's
// plaintext and streams it back out as four words. One block in flight.
//
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   in_valid/in_ready    : input handshake; in_data carries one word,
//   in_data, in_is_key     in_is_key selects key (1) or ciphertext (0)
//   out_valid/out_ready  : output handshake; out_data is a plaintext word
//   out_data
//   core_key_0..3        : to core key_0..3
//   core_ct_0..3         : to core cipher_text_0..3
//   core_pt_0..3         : from core decrypted_plain_text_0..3
//   busy                 : high while waiting on the core or unloading
//   block_count          : completed blocks, wraps modulo 2^CNT_W
module aes128_dec_stream_ctrl
    import aes128_pkg::*;
#(
    parameter int unsigned CORE_LATENCY = 12,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_is_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [31:0]      core_key_0,
    output logic [31:0]      core_key_1,
    output logic [31:0]      core_key_2,
    output logic [31:0]      core_key_3,
    output logic [31:0]      core_ct_0,
    output logic [31:0]      core_ct_1,
    output logic [31:0]      core_ct_2,
    output logic [31:0]      core_ct_3,
    input  logic [31:0]      core_pt_0,
    input  logic [31:0]      core_pt_1,
    input  logic [31:0]      core_pt_2,
    input  logic [31:0]      core_pt_3,
    output logic             busy,
    output logic [CNT_W-1:0] block_count
);

    localparam int unsigned LAT_W = $clog2(CORE_LATENCY + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

    state_e              state_q, state_d;
    logic [31:0]         key_q    [WORDS_PER_BLOCK];
    logic [31:0]         key_d    [WORDS_PER_BLOCK];
    logic [31:0]         ct_q     [WORDS_PER_BLOCK];
    logic [31:0]         ct_d     [WORDS_PER_BLOCK];
    logic [31:0]         pt_buf_q [WORDS_PER_BLOCK];
    logic [31:0]         pt_buf_d [WORDS_PER_BLOCK];
    logic [IDX_W-1:0]    key_idx_q, key_idx_d;
    logic [IDX_W-1:0]    ct_idx_q, ct_idx_d;
    logic [IDX_W-1:0]    out_idx_q, out_idx_d;
    logic [IDX_W-1:0]    out_idx_nxt;
    logic [LAT_W-1:0]    cnt_q, cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [31:0]         out_data_q, out_data_d;
    logic [CNT_W-1:0]    block_count_q, block_count_d;
    logic                in_acc;

    // Held low through reset so no word is taken while state is being cleared.
    assign in_ready    = (state_q == LOAD) && !reset;
    assign in_acc      = in_valid && in_ready;
    assign out_idx_nxt = out_idx_q + IDX_W'(1);

    always_comb begin
        state_d       = state_q;
        key_d         = key_q;
        ct_d          = ct_q;
        pt_buf_d      = pt_buf_q;
        key_idx_d     = key_idx_q;
        ct_idx_d      = ct_idx_q;
        out_idx_d     = out_idx_q;
        cnt_d         = cnt_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        block_count_d = block_count_q;

        unique case (state_q)
            LOAD: begin
                if (in_acc) begin
                    if (in_is_key) begin
                        key_d[key_idx_q] = in_data;
                        key_idx_d        = key_idx_q + IDX_W'(1);
                    end else begin
                        ct_d[ct_idx_q] = in_data;
                        ct_idx_d       = ct_idx_q + IDX_W'(1);
                        if (ct_idx_q == LAST_IDX) begin
                            cnt_d   = LAT_W'(CORE_LATENCY);
                            state_d = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - LAT_W'(1);
                // Last cycle of the core latency: its outputs are valid now.
                if (cnt_q == LAT_W'(1)) begin
                    pt_buf_d[0] = core_pt_0;
                    pt_buf_d[1] = core_pt_1;
                    pt_buf_d[2] = core_pt_2;
                    pt_buf_d[3] = core_pt_3;
                    out_idx_d   = '0;
                    state_d     = UNLOAD;
                end
            end
            UNLOAD: begin
                if (!out_valid_q) begin
                    // First UNLOAD cycle: present word 0 from the register.
                    out_valid_d = 1'b1;
                    out_data_d  = pt_buf_q[out_idx_q];
                end else if (out_ready) begin
                    if (out_idx_q == LAST_IDX) begin
                        out_valid_d   = 1'b0;
                        out_idx_d     = '0;
                        block_count_d = block_count_q + CNT_W'(1);
                        state_d       = LOAD;
                    end else begin
                        out_idx_d  = out_idx_nxt;
                        out_data_d = pt_buf_q[out_idx_nxt];
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= LOAD;
            key_idx_q     <= '0;
            ct_idx_q      <= '0;
            out_idx_q     <= '0;
            cnt_q         <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            block_count_q <= '0;
            for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
                key_q[i]    <= '0;
                ct_q[i]     <= '0;
                pt_buf_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            key_idx_q     <= key_idx_d;
            ct_idx_q      <= ct_idx_d;
            out_idx_q     <= out_idx_d;
            cnt_q         <= cnt_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            block_count_q <= block_count_d;
            key_q         <= key_d;
            ct_q          <= ct_d;
            pt_buf_q      <= pt_buf_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign busy        = (state_q == WAIT) || (state_q == UNLOAD);
    assign block_count = block_count_q;
    assign core_key_0  = key_q[0];
    assign core_key_1  = key_q[1];
    assign core_key_2  = key_q[2];
    assign core_key_3  = key_q[3];
    assign core_ct_0   = ct_q[0];
    assign core_ct_1   = ct_q[1];
    assign core_ct_2   = ct_q[2];
    assign core_ct_3   = ct_q[3];

endmodule

// File: tb/tb_aes128_dec_stream_ctrl.sv
// Scoreboard bench for aes128_dec_stream_ctrl. The core is modelled as a
// reference decrypt followed by a delay line, so outputs are only correct
// CORE_LATENCY cycles after the core inputs settle.
module tb_aes128_dec_stream_ctrl;

    localparam int unsigned LAT = 12;
    localparam int unsigned CW  = 2;

    localparam logic [127:0] FIPS_KEY = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
    localparam logic [127:0] FIPS_PT  = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] KEY2     = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    localparam logic [127:0] CT2      = 128'h13579bdf_2468ace0_fedcba98_76543210;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          in_is_key;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic [31:0]   core_key_0, core_key_1, core_key_2, core_key_3;
    logic [31:0]   core_ct_0, core_ct_1, core_ct_2, core_ct_3;
    logic [31:0]   core_pt_0, core_pt_1, core_pt_2, core_pt_3;
    logic          busy;
    logic [CW-1:0] block_count;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [31:0] exp_q[$];

    aes128_dec_stream_ctrl #(
        .CORE_LATENCY(LAT),
        .CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_is_key  (in_is_key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .core_key_0 (core_key_0),
        .core_key_1 (core_key_1),
        .core_key_2 (core_key_2),
        .core_key_3 (core_key_3),
        .core_ct_0  (core_ct_0),
        .core_ct_1  (core_ct_1),
        .core_ct_2  (core_ct_2),
        .core_ct_3  (core_ct_3),
        .core_pt_0  (core_pt_0),
        .core_pt_1  (core_pt_1),
        .core_pt_2  (core_pt_2),
        .core_pt_3  (core_pt_3),
        .busy       (busy),
        .block_count(block_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference decrypt: the FIPS-197 C.1 vector, otherwise a fixed mixing
    // function so non-FIPS blocks still have a checkable result.
    function automatic logic [127:0] ref_dec(input logic [127:0] k, input logic [127:0] c);
        if (k == FIPS_KEY && c == FIPS_CT) return FIPS_PT;
        return c ^ {k[63:0], k[127:64]} ^ 128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3;
    endfunction

    // Core model: combinational decrypt then LAT-1 register stages.
    logic [127:0] stage0;
    logic [127:0] dl [1:LAT-1];
    always_comb stage0 = ref_dec({core_key_3, core_key_2, core_key_1, core_key_0},
                                 {core_ct_3, core_ct_2, core_ct_1, core_ct_0});
    always @(posedge clk) begin
        dl[1] <= stage0;
        for (int i = 2; i < LAT; i++) dl[i] <= dl[i-1];
    end
    assign core_pt_0 = dl[LAT-1][31:0];
    assign core_pt_1 = dl[LAT-1][63:32];
    assign core_pt_2 = dl[LAT-1][95:64];
    assign core_pt_3 = dl[LAT-1][127:96];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Monitor: each presented word is compared with the queue head; it is
    // popped only when the sink accepts it.
    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_out: got %h required no output", out_data);
            end else if (out_ready) begin
                chk("out_word", {32'd0, out_data}, {32'd0, exp_q.pop_front()});
            end else begin
                chk("out_hold", {32'd0, out_data}, {32'd0, exp_q[0]});
            end
        end
    end

    task automatic push_exp(input logic [127:0] pt);
        for (int i = 0; i < 4; i++) exp_q.push_back(pt[32*i +: 32]);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] d, input logic k);
        bit ok = 1'b0;
        in_valid  = 1'b1;
        in_data   = d;
        in_is_key = k;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 required in_ready=1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic load_key(input logic [127:0] k);
        for (int i = 0; i < 4; i++) send(k[32*i +: 32], 1'b1);
    endtask

    task automatic load_ct(input logic [127:0] c);
        for (int i = 0; i < 4; i++) send(c[32*i +: 32], 1'b0);
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got %0d words pending required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL valid_timeout: got out_valid=0 required out_valid=1");
        end
    endtask

    initial begin
        int acc;
        bit ok;
        logic [127:0] pt2;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_is_key = 1'b0;
        out_ready = 1'b1;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_in_ready_low", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_count", {62'd0, block_count}, 64'd0);
        chk("rst_key0", {32'd0, core_key_0}, 64'd0);
        chk("rst_ct3", {32'd0, core_ct_3}, 64'd0);
        @(posedge clk);
        #1;

        // FIPS-197 C.1, latency, words offered during WAIT are ignored.
        push_exp(FIPS_PT);
        load_key(FIPS_KEY);
        load_ct(FIPS_CT);
        acc = cyc;
        in_valid  = 1'b1;
        in_is_key = 1'b1;
        in_data   = 32'hdeadbeef;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wait_in_ready", {63'd0, in_ready}, 64'd0);
            chk("wait_busy", {63'd0, busy}, 64'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(ok);
        if (ok) chk("latency", 64'(cyc - acc), 64'(LAT + 1));
        wait_done();
        chk("fips_count", {62'd0, block_count}, 64'd1);
        chk("wait_key0_kept", {32'd0, core_key_0}, 64'h0c0d0e0f);
        chk("ct0", {32'd0, core_ct_0}, 64'h70b4c55a);

        // Key reuse with backpressure on word 1.
        out_ready = 1'b0;
        push_exp(FIPS_PT);
        load_ct(FIPS_CT);
        wait_valid(ok);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_data", {32'd0, out_data}, 64'h8899aabb);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_done();
        chk("reuse_count", {62'd0, block_count}, 64'd2);

        // Key words interleaved with ciphertext words.
        pt2 = ref_dec(KEY2, CT2);
        push_exp(pt2);
        send(CT2[31:0], 1'b0);
        send(KEY2[31:0], 1'b1);
        send(CT2[63:32], 1'b0);
        send(KEY2[63:32], 1'b1);
        send(CT2[95:64], 1'b0);
        send(KEY2[95:64], 1'b1);
        send(KEY2[127:96], 1'b1);
        send(CT2[127:96], 1'b0);
        wait_done();
        chk("ilv_key0", {32'd0, core_key_0}, {32'd0, KEY2[31:0]});
        chk("ilv_key1", {32'd0, core_key_1}, {32'd0, KEY2[63:32]});
        chk("ilv_key2", {32'd0, core_key_2}, {32'd0, KEY2[95:64]});
        chk("ilv_key3", {32'd0, core_key_3}, {32'd0, KEY2[127:96]});
        chk("ilv_count", {62'd0, block_count}, 64'd3);

        // Reset while waiting on the core (cnt == 5): nothing may come out.
        load_key(FIPS_KEY);
        load_ct(FIPS_CT);
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
        chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_key0", {32'd0, core_key_0}, 64'd0);
        chk("abort_key3", {32'd0, core_key_3}, 64'd0);
        chk("abort_ct0", {32'd0, core_ct_0}, 64'd0);
        chk("abort_count", {62'd0, block_count}, 64'd0);
        repeat (40) @(negedge clk);
        chk("abort_idle_busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;

        // Counter wrap with a 2-bit block_count.
        for (int b = 0; b < 5; b++) begin
            if (b == 0) load_key(FIPS_KEY);
            push_exp(FIPS_PT);
            load_ct(FIPS_CT);
            wait_done();
            chk("wrap_count", {62'd0, block_count}, 64'((b + 1) % 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
